// File: rtl/dpcm_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dpcm_scheduler : round-robin time-multiplexer of one shared DPCM datapath
// Rev 1.0
// ============================================================================
module dpcm_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req_valid,
    output logic [NCH-1:0]         req_ready,
    input  logic [NCH*W-1:0]       req_data,
    input  logic                   ctx_clr,
    output logic [W-1:0]           dp_word_now,
    output logic [W-1:0]           dp_word_before,
    input  logic [W-1:0]           dp_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(NCH)-1:0] out_ch
);

    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  ctx_q [NCH];
    logic [W-1:0]  cur_q;
    logic [W-1:0]  now_hold_q;
    logic [W-1:0]  before_hold_q;
    logic [W-1:0]  out_data_q;
    logic [CW-1:0] ch_q;
    logic [CW-1:0] rr_ptr_q;
    logic [CW-1:0] out_ch_q;
    logic          out_valid_q;

    logic [CW-1:0] grant_d;
    logic [CW-1:0] idx_d;
    logic          found_d;
    logic [W-1:0]  sample_d;

    // First requester at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        grant_d = rr_ptr_q;
        found_d = 1'b0;
        idx_d   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_d = CW'((int'(rr_ptr_q) + k) % NCH);
            if (!found_d && req_valid[idx_d]) begin
                found_d = 1'b1;
                grant_d = idx_d;
            end
        end
    end

    assign sample_d = req_data[int'(grant_d)*W +: W];

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found_d) begin
            req_ready[grant_d] = 1'b1;
        end
    end

    // The shared unit sees live operands only in CALC; otherwise the last pair is held.
    assign dp_word_now    = (state_q == S_CALC) ? cur_q        : now_hold_q;
    assign dp_word_before = (state_q == S_CALC) ? ctx_q[ch_q]  : before_hold_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cur_q         <= '0;
            now_hold_q    <= '0;
            before_hold_q <= '0;
            out_data_q    <= '0;
            ch_q          <= '0;
            rr_ptr_q      <= '0;
            out_ch_q      <= '0;
            out_valid_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        cur_q   <= sample_d;
                        ch_q    <= grant_d;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    now_hold_q    <= cur_q;
                    before_hold_q <= ctx_q[ch_q];
                    out_data_q    <= dp_result;
                    out_ch_q      <= ch_q;
                    out_valid_q   <= 1'b1;
                    ctx_q[ch_q]   <= cur_q;
                    state_q       <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        rr_ptr_q    <= (ch_q == CW'(NCH - 1)) ? '0 : ch_q + 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Placed last so a clear overrides the CALC context write.
            if (ctx_clr) begin
                for (int i = 0; i < NCH; i++) begin
                    ctx_q[i] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
